// File: rtl/ucsbece154b_bpred_assoc.sv
// gshare predictor: N-way set-associative BTB with round-robin victims,
// speculative GHR with mispredict restore and a PHT init sequencer.
module ucsbece154b_bpred_assoc #(
    parameter int          NUM_BTB_SETS = 16,
    parameter int          NUM_BTB_WAYS = 2,
    parameter int          NUM_GHR_BITS = 5,
    parameter logic [1:0]  PHT_INIT     = 2'b01
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [31:0]             pc_i,
    input  logic                    fetch_en_i,
    output logic                    BranchTaken_o,
    output logic [31:0]             BTBtarget_o,
    output logic [NUM_GHR_BITS-1:0] PHTreadaddress_o,
    output logic [NUM_GHR_BITS-1:0] GHRsnap_o,
    output logic                    ready_o,
    input  logic                    upd_valid_i,
    input  logic [31:0]             upd_pc_i,
    input  logic [31:0]             upd_target_i,
    input  logic                    upd_is_branch_i,
    input  logic                    upd_is_jump_i,
    input  logic                    upd_taken_i,
    input  logic                    upd_mispredict_i,
    input  logic [NUM_GHR_BITS-1:0] upd_phtaddr_i,
    input  logic [NUM_GHR_BITS-1:0] upd_ghr_i
);

    localparam int S     = $clog2(NUM_BTB_SETS);
    localparam int G     = NUM_GHR_BITS;
    localparam int W     = NUM_BTB_WAYS;
    localparam int TW    = 30 - S;
    localparam int WB    = (W > 1) ? $clog2(W) : 1;
    localparam int PHT_N = 1 << G;

    typedef enum logic {INIT, RUN} state_e;

    state_e           state_q;
    logic             ready_q;
    logic [G-1:0]     init_cnt_q;
    logic [G-1:0]     ghr_q, ghr_d;
    logic [1:0]       pht_q   [PHT_N];
    logic [W-1:0]     valid_q [NUM_BTB_SETS];
    logic [WB-1:0]    vic_q   [NUM_BTB_SETS];
    logic [TW-1:0]    tag_q   [NUM_BTB_SETS][W];
    logic [31:0]      tgt_q   [NUM_BTB_SETS][W];
    logic             jflag_q [NUM_BTB_SETS][W];
    logic             bflag_q [NUM_BTB_SETS][W];

    logic             run;
    logic [S-1:0]     f_set, u_set;
    logic [TW-1:0]    f_tag, u_tag;
    logic             f_hit, f_j, f_b, pred;
    logic [WB-1:0]    f_way;
    logic [1:0]       pht_rd, pht_u, pht_new;
    logic             u_match, u_inv, u_evict;
    logic [WB-1:0]    u_mway, u_iway, u_way, vic_nxt;
    logic             btb_we, pht_we;
    logic             unused_ok;

    assign run       = (state_q == RUN);
    assign unused_ok = ^{pc_i[1:0], upd_pc_i[1:0]};

    // Fetch-side lookup
    assign f_set = pc_i[S+1:2];
    assign f_tag = pc_i[31:S+2];

    always_comb begin
        f_hit = 1'b0;
        f_way = '0;
        for (int w = 0; w < W; w++) begin
            if (valid_q[f_set][w] && tag_q[f_set][w] == f_tag) begin
                f_hit = 1'b1;
                f_way = WB'(w);
            end
        end
    end

    assign f_j              = jflag_q[f_set][f_way];
    assign f_b              = bflag_q[f_set][f_way];
    assign PHTreadaddress_o = pc_i[G+1:2] ^ ghr_q;
    assign pht_rd           = pht_q[PHTreadaddress_o];
    assign pred             = f_hit & (f_j | (f_b & pht_rd[1]));
    assign BranchTaken_o    = run & pred;
    assign BTBtarget_o      = (run & f_hit) ? tgt_q[f_set][f_way] : 32'h0;
    assign GHRsnap_o        = ghr_q;
    assign ready_o          = ready_q;

    // Execute-side way selection: existing tag, else lowest invalid, else victim
    assign u_set = upd_pc_i[S+1:2];
    assign u_tag = upd_pc_i[31:S+2];

    always_comb begin
        u_match = 1'b0;
        u_mway  = '0;
        u_inv   = 1'b0;
        u_iway  = '0;
        for (int w = W - 1; w >= 0; w--) begin
            if (valid_q[u_set][w] && tag_q[u_set][w] == u_tag) begin
                u_match = 1'b1;
                u_mway  = WB'(w);
            end
            if (!valid_q[u_set][w]) begin
                u_inv  = 1'b1;
                u_iway = WB'(w);
            end
        end
    end

    assign u_way   = u_match ? u_mway : (u_inv ? u_iway : vic_q[u_set]);
    assign u_evict = ~u_match & ~u_inv;
    assign vic_nxt = (vic_q[u_set] == WB'(W - 1)) ? '0 : vic_q[u_set] + 1'b1;

    assign btb_we = run & upd_valid_i & upd_taken_i
                  & (upd_is_branch_i | upd_is_jump_i);
    assign pht_we = run & upd_valid_i & upd_is_branch_i;

    assign pht_u = pht_q[upd_phtaddr_i];

    always_comb begin
        pht_new = pht_u;
        if (upd_taken_i) begin
            if (pht_u != 2'b11) pht_new = pht_u + 2'b01;
        end else begin
            if (pht_u != 2'b00) pht_new = pht_u - 2'b01;
        end
    end

    // Restore is applied last so it overrides the speculative shift
    always_comb begin
        ghr_d = ghr_q;
        if (run && fetch_en_i && f_hit && f_b)
            ghr_d = {ghr_q[G-2:0], pred};
        if (run && upd_valid_i && upd_mispredict_i)
            ghr_d = upd_is_branch_i ? {upd_ghr_i[G-2:0], upd_taken_i}
                                    : upd_ghr_i;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= INIT;
            ready_q    <= 1'b0;
            init_cnt_q <= '0;
            ghr_q      <= '0;
            for (int s = 0; s < NUM_BTB_SETS; s++) begin
                valid_q[s] <= '0;
                vic_q[s]   <= '0;
            end
        end else begin
            ghr_q <= ghr_d;
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == '1) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: state_q <= INIT;
            endcase
            if (btb_we) valid_q[u_set][u_way] <= 1'b1;
            if (btb_we && u_evict) vic_q[u_set] <= vic_nxt;
        end
    end

    // Storage without reset; PHT contents are rebuilt by the init pass
    always_ff @(posedge clk) begin
        if (btb_we) begin
            tag_q[u_set][u_way]   <= u_tag;
            tgt_q[u_set][u_way]   <= upd_target_i;
            jflag_q[u_set][u_way] <= upd_is_jump_i;
            bflag_q[u_set][u_way] <= upd_is_branch_i;
        end
        if (state_q == INIT)
            pht_q[init_cnt_q] <= PHT_INIT;
        else if (pht_we)
            pht_q[upd_phtaddr_i] <= pht_new;
    end

endmodule

// File: tb/tb_ucsbece154b_bpred_assoc.sv
// Directed bench for ucsbece154b_bpred_assoc with a per-cycle
// reference model of BTB, PHT and GHR behaviour.
module tb_ucsbece154b_bpred_assoc;

    localparam int G    = 5;
    localparam int NS   = 16;
    localparam int NW   = 2;
    localparam int MASK = (1 << G) - 1;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] pc_i = '0;
    logic        fetch_en_i = 1'b0;
    logic        BranchTaken_o;
    logic [31:0] BTBtarget_o;
    logic [G-1:0] PHTreadaddress_o;
    logic [G-1:0] GHRsnap_o;
    logic        ready_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic [31:0] upd_target_i = '0;
    logic        upd_is_branch_i = 1'b0;
    logic        upd_is_jump_i = 1'b0;
    logic        upd_taken_i = 1'b0;
    logic        upd_mispredict_i = 1'b0;
    logic [G-1:0] upd_phtaddr_i = '0;
    logic [G-1:0] upd_ghr_i = '0;

    ucsbece154b_bpred_assoc #(
        .NUM_BTB_SETS(NS), .NUM_BTB_WAYS(NW),
        .NUM_GHR_BITS(G), .PHT_INIT(2'b01)
    ) dut (
        .clk(clk), .reset_i(reset_i), .pc_i(pc_i), .fetch_en_i(fetch_en_i),
        .BranchTaken_o(BranchTaken_o), .BTBtarget_o(BTBtarget_o),
        .PHTreadaddress_o(PHTreadaddress_o), .GHRsnap_o(GHRsnap_o),
        .ready_o(ready_o), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
        .upd_target_i(upd_target_i), .upd_is_branch_i(upd_is_branch_i),
        .upd_is_jump_i(upd_is_jump_i), .upd_taken_i(upd_taken_i),
        .upd_mispredict_i(upd_mispredict_i), .upd_phtaddr_i(upd_phtaddr_i),
        .upd_ghr_i(upd_ghr_i)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: BTB keyed by word address within its set
    typedef struct {
        bit          v;
        bit [29:0]   key;
        logic [31:0] tgt;
        bit          j;
        bit          b;
    } ent_t;

    ent_t mbtb [NS][NW];
    int   mptr [NS];
    int   mpht [1 << G];
    int   mghr = 0;
    bit   mrun = 0;
    int   minit = 0;

    function automatic int mset(input logic [31:0] pc);
        return int'((pc >> 2) & (NS - 1));
    endfunction

    function automatic int mfind(input logic [31:0] pc);
        int s = mset(pc);
        for (int w = 0; w < NW; w++)
            if (mbtb[s][w].v && mbtb[s][w].key == pc[31:2]) return w;
        return -1;
    endfunction

    function automatic bit mpred(input logic [31:0] pc);
        int s = mset(pc);
        int w = mfind(pc);
        int idx = int'((pc >> 2) & MASK) ^ mghr;
        if (w < 0) return 1'b0;
        return mbtb[s][w].j || (mbtb[s][w].b && mpht[idx] >= 2);
    endfunction

    task automatic model_step();
        int s, w, ng, idx;
        bit p;
        if (reset_i) begin
            mrun = 0;
            minit = 0;
            mghr = 0;
            for (int i = 0; i < NS; i++) begin
                mptr[i] = 0;
                for (int k = 0; k < NW; k++) mbtb[i][k].v = 0;
            end
        end else if (!mrun) begin
            minit++;
            if (minit == (1 << G)) begin
                mrun = 1;
                for (int i = 0; i < (1 << G); i++) mpht[i] = 1;
            end
        end else begin
            p  = mpred(pc_i);
            w  = mfind(pc_i);
            s  = mset(pc_i);
            ng = mghr;
            if (fetch_en_i && w >= 0 && mbtb[s][w].b)
                ng = ((mghr << 1) | int'(p)) & MASK;
            if (upd_valid_i) begin
                if (upd_is_branch_i) begin
                    idx = int'(upd_phtaddr_i);
                    if (upd_taken_i) begin
                        if (mpht[idx] < 3) mpht[idx]++;
                    end else if (mpht[idx] > 0) mpht[idx]--;
                end
                if (upd_taken_i && (upd_is_branch_i || upd_is_jump_i)) begin
                    s = mset(upd_pc_i);
                    w = mfind(upd_pc_i);
                    for (int k = 0; k < NW; k++)
                        if (w < 0 && !mbtb[s][k].v) w = k;
                    if (w < 0) begin
                        w = mptr[s];
                        mptr[s] = (mptr[s] + 1) % NW;
                    end
                    mbtb[s][w].v   = 1;
                    mbtb[s][w].key = upd_pc_i[31:2];
                    mbtb[s][w].tgt = upd_target_i;
                    mbtb[s][w].j   = upd_is_jump_i;
                    mbtb[s][w].b   = upd_is_branch_i;
                end
                if (upd_mispredict_i)
                    ng = upd_is_branch_i
                       ? (((int'(upd_ghr_i) << 1) | int'(upd_taken_i)) & MASK)
                       : int'(upd_ghr_i);
            end
            mghr = ng;
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (!reset_i) begin
            int w;
            logic [31:0] etgt;
            w = mfind(pc_i);
            etgt = (mrun && w >= 0) ? mbtb[mset(pc_i)][w].tgt : 32'h0;
            chk("m_ready", 32'(ready_o), 32'(mrun));
            chk("m_taken", 32'(BranchTaken_o), mrun ? 32'(mpred(pc_i)) : 32'h0);
            chk("m_target", BTBtarget_o, etgt);
            chk("m_phtaddr", 32'(PHTreadaddress_o),
                32'((int'((pc_i >> 2) & MASK) ^ mghr)));
            chk("m_ghr", 32'(GHRsnap_o), 32'(mghr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input bit br, input bit j, input bit tk, input bit mp,
                       input logic [G-1:0] pa, input logic [G-1:0] gh);
        upd_valid_i      = 1'b1;
        upd_pc_i         = pc;
        upd_target_i     = tgt;
        upd_is_branch_i  = br;
        upd_is_jump_i    = j;
        upd_taken_i      = tk;
        upd_mispredict_i = mp;
        upd_phtaddr_i    = pa;
        upd_ghr_i        = gh;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input bit bt, input logic [31:0] tgt);
        pc_i = pc;
        #1;
        chk({name, "_bt"}, 32'(BranchTaken_o), 32'(bt));
        chk({name, "_tgt"}, BTBtarget_o, tgt);
    endtask

    initial begin
        // Reset and init pass; an update offered during INIT must be dropped
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 32'h0);
        chk("rst_ghr", 32'(GHRsnap_o), 32'h0);
        chk("rst_bt", 32'(BranchTaken_o), 32'h0);
        reset_i = 1'b0;
        pc_i = 32'h200;
        upd(32'h200, 32'h300, 0, 1, 1, 0, '0, '0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 4) upd_valid_i = 1'b0;
            chk("init_ready", 32'(ready_o), (i == 32) ? 32'h1 : 32'h0);
            chk("init_bt", 32'(BranchTaken_o), 32'h0);
        end

        // Jump allocation
        upd(32'h40, 32'h100, 0, 1, 1, 0, '0, '0);
        tick();
        upd_valid_i = 1'b0;
        lookup("init_drop", 32'h200, 0, 32'h0);
        lookup("jal_hit", 32'h40, 1, 32'h100);
        lookup("jal_miss", 32'h44, 0, 32'h0);

        // PHT training at index 0 (pc 0x80, GHR 0)
        upd(32'h80, 32'h20, 1, 0, 1, 0, '0, '0);
        lookup("nobypass", 32'h80, 0, 32'h0);
        tick();
        upd_valid_i = 1'b0;
        lookup("pht_10", 32'h80, 1, 32'h20);
        for (int i = 0; i < 3; i++) begin
            upd(32'h80, 32'h20, 1, 0, 1, 0, '0, '0);
            tick();
        end
        upd(32'h80, 32'h20, 1, 0, 0, 0, '0, '0);
        tick();
        upd_valid_i = 1'b0;
        lookup("pht_11_nt1", 32'h80, 1, 32'h20);
        for (int i = 0; i < 3; i++) begin
            upd(32'h80, 32'h20, 1, 0, 0, 0, '0, '0);
            tick();
        end
        upd_valid_i = 1'b0;
        lookup("pht_00", 32'h80, 0, 32'h20);

        // Load GHR via a mispredict restore, then async reset between edges
        upd(32'h0, 32'h0, 0, 0, 0, 1, '0, 5'b10101);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("ghr_load", 32'(GHRsnap_o), 32'h15);
        lookup("pre_rst", 32'h40, 1, 32'h100);
        reset_i = 1'b1;
        #1;
        chk("arst_ready", 32'(ready_o), 32'h0);
        chk("arst_bt", 32'(BranchTaken_o), 32'h0);
        chk("arst_ghr", 32'(GHRsnap_o), 32'h0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int i = 1; i <= 32; i++) tick();
        chk("reinit_ready", 32'(ready_o), 32'h1);
        lookup("reinit_40", 32'h40, 0, 32'h0);
        lookup("reinit_80", 32'h80, 0, 32'h0);

        // Round-robin replacement in set 0
        upd(32'h000, 32'h1000, 0, 1, 1, 0, '0, '0);
        tick();
        upd(32'h040, 32'h1040, 0, 1, 1, 0, '0, '0);
        tick();
        upd(32'h080, 32'h1080, 0, 1, 1, 0, '0, '0);
        tick();
        upd_valid_i = 1'b0;
        lookup("rr_000", 32'h000, 0, 32'h0);
        lookup("rr_040", 32'h040, 1, 32'h1040);
        lookup("rr_080", 32'h080, 1, 32'h1080);
        upd(32'h0C0, 32'h10C0, 0, 1, 1, 0, '0, '0);
        tick();
        upd_valid_i = 1'b0;
        lookup("rr2_040", 32'h040, 0, 32'h0);
        lookup("rr2_080", 32'h080, 1, 32'h1080);
        lookup("rr2_0c0", 32'h0C0, 1, 32'h10C0);

        // Speculative GHR shift, then restore winning over a shift
        upd(32'h104, 32'h300, 1, 0, 1, 0, 5'd1, '0);
        tick();
        upd_valid_i = 1'b0;
        fetch_en_i = 1'b1;
        lookup("spec_a", 32'h104, 1, 32'h300);
        chk("spec_a_ghr", 32'(GHRsnap_o), 32'h0);
        tick();
        chk("spec_shift", 32'(GHRsnap_o), 32'h1);
        chk("spec_b_addr", 32'(PHTreadaddress_o), 32'h0);
        upd(32'h104, 32'h300, 1, 0, 0, 1, 5'd0, 5'd0);
        tick();
        fetch_en_i = 1'b0;
        upd_valid_i = 1'b0;
        #1;
        chk("restore_wins", 32'(GHRsnap_o), 32'h0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
